mem_access_ctrl: RTL and testbench

// - MEM-stage load/store initiator driving the word-wide data memory (combinational read, posedge word write).
// - Converts LW/LH/LHU/LB/LBU/SW/SH/SB requests to word accesses; sub-word stores use a 2-cycle read-modify-write.
// - Checks alignment and range; returns registered, extended load data; stalls the pipeline during RMW.

---
 rtl/mem_access_ctrl_pkg.sv | 47 ++++
 rtl/mem_access_ctrl_load_extend.sv | 35 +++
 rtl/mem_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store initiator.
// Contents: op encodings, controller state enum, op classification helpers,
// and the sub-word alignment check used by both the fault logic and the bench.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } mac_state_e;

    function automatic logic is_load(input mem_op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_sub_store(input mem_op_e op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

    // Word ops need addr[1:0]==0, half ops need addr[0]==0, byte ops never fault here.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lane);
        logic r;
        r = 1'b0;
        case (op)
            OP_LW, OP_SW:          r = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH:  r = lane[0];
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load lane extraction and extension (purely combinational).
// Ports:
//   i_word  - 32-bit word read from data memory
//   i_lane  - byte address bits [1:0] of the load
//   i_op    - load op (LW/LH/LHU/LB/LBU); any other op yields 0
//   o_data  - extended load data
module load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lanes: byte k at [8k+7:8k], half h at [16h+15:16h].
    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_data = 32'd0;
        case (mem_op_e'(i_op))
            OP_LW:   o_data = i_word;
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'd0, w_half};
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'd0, w_byte};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator for a word-wide data memory with
// combinational read and posedge word write.
// Loads, SW and faults complete in one cycle; SH/SB use a two-cycle
// read-modify-write and stall upstream through o_busy while writing back.
// Ports:
//   i_clk, i_reset       - clock, synchronous active-high reset
//   i_req_*              - request (valid, op, byte addr, store data, pc)
//   o_busy               - stall, high while the merged word is being written
//   o_rsp_*              - registered completion pulse, load data, fault flags
//   o_dm_* / i_dm_rd     - data memory interface
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DM_DEPTH = 1024,
    parameter int ADDR_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic [2:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [31:0]       i_req_pc,
    output logic              o_busy,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_adel,
    output logic              o_rsp_ades,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [31:0]       o_dm_wd,
    output logic              o_dm_re,
    output logic              o_dm_we,
    input  logic [31:0]       i_dm_rd,
    output logic [31:0]       o_dm_pc
);

    localparam logic [ADDR_W-1:0] DM_BYTES = ADDR_W'(DM_DEPTH * 4);

    mac_state_e        r_state;
    logic [31:0]       r_merge;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_pc;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_adel;
    logic              r_rsp_ades;

    mem_op_e           w_op;
    logic [1:0]        w_lane;
    logic              w_accept;
    logic              w_fault;
    logic [ADDR_W-1:0] w_word_addr;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge;

    assign w_op        = mem_op_e'(i_req_op);
    assign w_lane      = i_req_addr[1:0];
    assign w_accept    = (r_state == ST_IDLE) && i_req_valid;
    assign w_fault     = is_misaligned(w_op, w_lane) || (i_req_addr >= DM_BYTES);
    assign w_word_addr = {i_req_addr[ADDR_W-1:2], 2'b00};

    load_extend u_load_extend (
        .i_word (i_dm_rd),
        .i_lane (w_lane),
        .i_op   (i_req_op),
        .o_data (w_load_data)
    );

    // Store lane merged over the word read in the first RMW cycle.
    always_comb begin
        w_merge = i_dm_rd;
        if (w_op == OP_SB) begin
            w_merge[{w_lane, 3'b000} +: 8] = i_req_wdata[7:0];
        end else if (w_op == OP_SH) begin
            w_merge[{w_lane[1], 4'b0000} +: 16] = i_req_wdata[15:0];
        end
    end

    // Both enables are forced low during reset so an in-flight RMW write is dropped.
    // dm_re only ever fires in IDLE and dm_we in IDLE only for SW, so they never overlap.
    assign o_dm_re = !i_reset && w_accept && !w_fault &&
                     (is_load(w_op) || is_sub_store(w_op));
    assign o_dm_we = !i_reset &&
                     ((r_state == ST_RMW_WR) || (w_accept && !w_fault && (w_op == OP_SW)));

    assign o_busy    = (r_state == ST_RMW_WR);
    assign o_dm_addr = (r_state == ST_RMW_WR) ? r_addr  : w_word_addr;
    assign o_dm_wd   = (r_state == ST_RMW_WR) ? r_merge : i_req_wdata;
    assign o_dm_pc   = (r_state == ST_RMW_WR) ? r_pc    : i_req_pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_merge     <= 32'd0;
            r_addr      <= '0;
            r_pc        <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_adel  <= 1'b0;
            r_rsp_ades  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_adel  <= 1'b0;
            r_rsp_ades  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        if (w_fault) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_adel  <= is_load(w_op);
                            r_rsp_ades  <= is_store(w_op);
                        end else if (is_load(w_op)) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_load_data;
                        end else if (w_op == OP_SW) begin
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_merge <= w_merge;
                            r_addr  <= w_word_addr;
                            r_pc    <= i_req_pc;
                            r_state <= ST_RMW_WR;
                        end
                    end
                end
                ST_RMW_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_adel  = r_rsp_adel;
    assign o_rsp_ades  = r_rsp_ades;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_adel;
    logic        rsp_ades;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_re;
    logic        dm_we;
    logic [31:0] dm_rd;
    logic [31:0] dm_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] mem [0:1023];
    logic [31:0] model_mem [0:15];

    mem_access_ctrl #(.DM_DEPTH(1024), .ADDR_W(32)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .i_req_op    (req_op),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_pc    (req_pc),
        .o_busy      (busy),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_adel  (rsp_adel),
        .o_rsp_ades  (rsp_ades),
        .o_dm_addr   (dm_addr),
        .o_dm_wd     (dm_wd),
        .o_dm_re     (dm_re),
        .o_dm_we     (dm_we),
        .i_dm_rd     (dm_rd),
        .o_dm_pc     (dm_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, posedge word write.
    assign dm_rd = (dm_addr < 32'h1000) ? mem[dm_addr[11:2]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (dm_we && dm_addr < 32'h1000) mem[dm_addr[11:2]] <= dm_wd;
    end

    // Response scoreboard and enable exclusivity monitor.
    always @(negedge clk) begin
        exp_t e;
        if (dm_re || dm_we) begin
            checks++;
            if (dm_re && dm_we) begin
                failures++;
                $display("FAIL re_we_overlap: dm_re=%0b dm_we=%0b required not both", dm_re, dm_we);
            end
        end
        if (!reset && rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp: rdata=%h adel=%0b ades=%0b with nothing expected",
                         rsp_rdata, rsp_adel, rsp_ades);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_rdata, rsp_adel, rsp_ades} !== {e.rdata, e.adel, e.ades}) begin
                    failures++;
                    $display("FAIL rsp_%s: got rdata=%h adel=%0b ades=%0b required rdata=%h adel=%0b ades=%0b",
                             e.name, rsp_rdata, rsp_adel, rsp_ades, e.rdata, e.adel, e.ades);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] rd, input logic adel, input logic ades, input string name);
        exp_t e;
        e.rdata = rd; e.adel = adel; e.ades = ades; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] pc);
        req_valid = v; req_op = op; req_addr = a; req_wdata = wd; req_pc = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = (a == 2'd0) ? w[7:0] : (a == 2'd1) ? w[15:8] : (a == 2'd2) ? w[23:16] : w[31:24];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            LW:      return w;
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, SW, 32'h10, 32'h1234_5678, 32'h0);
        tick();
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid, rsp_adel, rsp_ades, rsp_rdata} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%0b rsp_valid=%0b adel=%0b ades=%0b rdata=%h required all 0",
                     busy, rsp_valid, rsp_adel, rsp_ades, rsp_rdata);
        end
        checks++;
        if ({dm_re, dm_we} !== 2'b00) begin
            failures++;
            $display("FAIL reset_dm_en: dm_re=%0b dm_we=%0b required 0 0", dm_re, dm_we);
        end
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_sw_lw();
        drive(1'b1, SW, 32'h10, 32'hA1B2_C3D4, 32'h100);
        push_exp(32'h0, 1'b0, 1'b0, "sw10");
        @(negedge clk);
        checks++;
        if ({dm_we, dm_re, dm_wd, dm_addr, dm_pc} !== {1'b1, 1'b0, 32'hA1B2_C3D4, 32'h10, 32'h100}) begin
            failures++;
            $display("FAIL sw_dm: we=%0b re=%0b wd=%h addr=%h pc=%h required 1 0 a1b2c3d4 00000010 00000100",
                     dm_we, dm_re, dm_wd, dm_addr, dm_pc);
        end
        tick();
        drive(1'b1, LW, 32'h10, 32'h0, 32'h104);
        push_exp(32'hA1B2_C3D4, 1'b0, 1'b0, "lw10");
        @(negedge clk);
        checks++;
        if ({dm_re, dm_we} !== 2'b10) begin
            failures++;
            $display("FAIL lw_dm_en: re=%0b we=%0b required 1 0", dm_re, dm_we);
        end
        tick();
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_load_extend();
        logic [2:0]  ops [6];
        logic [31:0] adr [6];
        logic [31:0] exv [6];
        ops = '{LB, LBU, LH, LHU, LB, LBU};
        adr = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h13, 32'h10};
        exv = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8070, 32'h0000_8070, 32'hFFFF_FF80, 32'h0000_00FF};
        drive(1'b1, SW, 32'h10, 32'h8070_F0FF, 32'h200);
        push_exp(32'h0, 1'b0, 1'b0, "sw_ext");
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], adr[i], 32'h0, 32'h204 + 32'(i * 4));
            push_exp(exv[i], 1'b0, 1'b0, $sformatf("ext%0d", i));
            tick();
        end
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_rmw();
        drive(1'b1, SW, 32'h10, 32'hA1B2_C3D4, 32'h300);
        push_exp(32'h0, 1'b0, 1'b0, "sw_rmw");
        tick();
        drive(1'b1, SB, 32'h13, 32'h0000_0055, 32'h304);
        push_exp(32'h0, 1'b0, 1'b0, "sb13");
        @(negedge clk);
        checks++;
        if ({dm_re, dm_we, busy} !== 3'b100) begin
            failures++;
            $display("FAIL sb_read: re=%0b we=%0b busy=%0b required 1 0 0", dm_re, dm_we, busy);
        end
        tick();
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({busy, dm_we, dm_re, dm_wd, dm_addr, dm_pc} !== {3'b110, 32'h55B2_C3D4, 32'h10, 32'h304}) begin
            failures++;
            $display("FAIL sb_write: busy=%0b we=%0b re=%0b wd=%h addr=%h pc=%h required 1 1 0 55b2c3d4 00000010 00000304",
                     busy, dm_we, dm_re, dm_wd, dm_addr, dm_pc);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL sb_busy_len: busy=%0b required 0", busy);
        end
        drive(1'b1, SH, 32'h10, 32'h0000_BEEF, 32'h308);
        push_exp(32'h0, 1'b0, 1'b0, "sh10");
        tick();
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({dm_we, dm_wd} !== {1'b1, 32'h55B2_BEEF}) begin
            failures++;
            $display("FAIL sh_write: we=%0b wd=%h required 1 55b2beef", dm_we, dm_wd);
        end
        tick();
        drive(1'b1, LW, 32'h10, 32'h0, 32'h30C);
        push_exp(32'h55B2_BEEF, 1'b0, 1'b0, "lw_after_sh");
        tick();
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_faults();
        logic [2:0]  ops [5];
        logic [31:0] adr [5];
        logic        ld  [5];
        ops = '{LW, SH, SW, LB, LHU};
        adr = '{32'h12, 32'h11, 32'h1000, 32'h1003, 32'h13};
        ld  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], adr[i], 32'hFFFF_FFFF, 32'h400);
            push_exp(32'h0, ld[i], !ld[i], $sformatf("fault%0d", i));
            @(negedge clk);
            checks++;
            if ({dm_re, dm_we} !== 2'b00) begin
                failures++;
                $display("FAIL fault%0d_dm_en: re=%0b we=%0b required 0 0", i, dm_re, dm_we);
            end
            tick();
        end
        drive(1'b1, SW, 32'hFFC, 32'h1357_9BDF, 32'h410);
        push_exp(32'h0, 1'b0, 1'b0, "sw_last");
        tick();
        drive(1'b1, LW, 32'hFFC, 32'h0, 32'h414);
        push_exp(32'h1357_9BDF, 1'b0, 1'b0, "lw_last");
        tick();
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, SW, 32'h20, 32'h1122_3344, 32'h500);
        push_exp(32'h0, 1'b0, 1'b0, "sw20");
        tick();
        drive(1'b1, SB, 32'h20, 32'h0000_00AA, 32'h504);
        push_exp(32'h0, 1'b0, 1'b0, "sb20");
        tick();
        drive(1'b1, LW, 32'h20, 32'h0, 32'h508);
        @(negedge clk);
        checks++;
        if ({busy, dm_re, dm_we, dm_wd} !== {3'b101, 32'h1122_33AA}) begin
            failures++;
            $display("FAIL b2b_held: busy=%0b re=%0b we=%0b wd=%h required 1 0 1 112233aa",
                     busy, dm_re, dm_we, dm_wd);
        end
        tick();
        push_exp(32'h1122_33AA, 1'b0, 1'b0, "b2b_lw");
        @(negedge clk);
        checks++;
        if ({busy, dm_re} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_accept: busy=%0b re=%0b required 0 1", busy, dm_re);
        end
        tick();
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_rmw();
        drive(1'b1, SW, 32'h30, 32'hCAFE_F00D, 32'h600);
        push_exp(32'h0, 1'b0, 1'b0, "sw30");
        tick();
        drive(1'b1, SB, 32'h30, 32'h0000_0077, 32'h604);
        tick();
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dm_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_rmw_we: dm_we=%0b required 0", dm_we);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL rst_rmw_state: busy=%0b rsp_valid=%0b required 0 0", busy, rsp_valid);
        end
        checks++;
        if (mem[12] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL rst_rmw_mem: word=%h required cafef00d", mem[12]);
        end
        tick();
        drive(1'b1, LW, 32'h30, 32'h0, 32'h608);
        push_exp(32'hCAFE_F00D, 1'b0, 1'b0, "lw30");
        tick();
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] w;
        logic        flt;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model_mem[i] = wd;
            drive(1'b1, SW, 32'(i * 4), wd, 32'h700);
            push_exp(32'h0, 1'b0, 1'b0, "rnd_init");
            tick();
        end
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = a + 32'h1000;
            wd = $urandom;
            flt = (a >= 32'h1000) ||
                  (((op == LW) || (op == SW)) && (a[1:0] != 2'b00)) ||
                  (((op == LH) || (op == LHU) || (op == SH)) && a[0]);
            w = model_mem[a[5:2]];
            drive(1'b1, op, a, wd, 32'h800 + 32'(n));
            if (flt) begin
                push_exp(32'h0, op < SW, op >= SW, $sformatf("rnd%0d", n));
            end else if (op < SW) begin
                push_exp(model_load(w, a[1:0], op), 1'b0, 1'b0, $sformatf("rnd%0d", n));
            end else begin
                push_exp(32'h0, 1'b0, 1'b0, $sformatf("rnd%0d", n));
                if (op == SW) w = wd;
                else if (op == SH) begin
                    if (a[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
                end else begin
                    case (a[1:0])
                        2'd0: w[7:0]   = wd[7:0];
                        2'd1: w[15:8]  = wd[7:0];
                        2'd2: w[23:16] = wd[7:0];
                        default: w[31:24] = wd[7:0];
                    endcase
                end
                model_mem[a[5:2]] = w;
            end
            tick();
            if (!flt && (op == SH || op == SB)) begin
                drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
                tick();
            end
        end
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        drive(1'b0, LW, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        test_reset();
        test_sw_lw();
        test_load_extend();
        test_rmw();
        test_faults();
        test_back_to_back();
        test_reset_rmw();
        test_random();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_rsp: outstanding=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
